boot_loader: RTL and testbench

//   Byte-stream program loader that sits directly upstream of the CPU's instruction RAM.
//   It receives a framed image over a valid/ready byte interface and assembles bytes into words.
//   It writes the words into RAM from address 0, verifies an XOR checksum, and releases the CPU

---
 rtl/boot_loader.sv | 132 +++++++++++++
 tb/tb_boot_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream loader that fills instruction RAM and releases CPU reset
module boot_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              remaining;
    logic [7:0]              csum;
    logic [BIW-1:0]          byte_idx;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   word;
    logic [DATA_WIDTH-1:0]   word_next;
    logic                    accept;
    logic                    last_byte;

    // in_ready is gated by rst so upstream sees no handshake while reset is held
    assign in_ready  = rst && ((state == S_COUNT) || (state == S_DATA) || (state == S_CSUM));
    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_idx == BIW'(BPW - 1));
    assign word_next = (word << 8) | DATA_WIDTH'(in_data);

    assign done    = (state == S_DONE);
    assign error   = (state == S_ERR);
    assign cpu_rst = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_COUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_COUNT: begin
                if (accept) begin
                    state_next = (in_data == 8'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (accept && last_byte) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = (remaining == 8'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_COUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            csum      <= '0;
            byte_idx  <= '0;
            addr      <= '0;
            word      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_COUNT: begin
                    if (accept) begin
                        remaining <= in_data;
                        addr      <= '0;
                        byte_idx  <= '0;
                        csum      <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word <= word_next;
                        csum <= csum ^ in_data;
                        if (last_byte) begin
                            // The write fires from registers during S_WRITE
                            byte_idx  <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= word_next;
                        end else begin
                            byte_idx <= byte_idx + BIW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    addr      <= addr + ADDR_WIDTH'(1);
                    remaining <= remaining - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed bench for boot_loader with a small RAM scoreboard
module tb_boot_loader;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem_model [4];
    logic [AW-1:0] addr_log [$];
    int            we_count = 0;
    logic [7:0]    stim [$];

    boot_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            addr_log.push_back(mem_addr);
            we_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 4; i++) mem_model[i] = '0;
        addr_log.delete();
        we_count = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        clear_board();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        int waitc;
        waitc = 0;
        @(negedge clk);
        if (gapped) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_all(input bit gapped);
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gapped);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_board();
        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Test 1: basic load with valid held high
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("t1_we_latency", 32'(mem_we), 32'd1);
        check("t1_w0_addr", 32'(mem_addr), 32'd0);
        check("t1_w0_data", 32'(mem_wdata), 32'h1234);
        check("t1_write_ready", 32'(in_ready), 32'd0);
        send_byte(8'hAB, 1'b0);
        check("t1_we_single", 32'(mem_we), 32'd0);
        send_byte(8'hCD, 1'b0);
        check("t1_w1_addr", 32'(mem_addr), 32'd1);
        send_byte(8'h40, 1'b0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_ready_off", 32'(in_ready), 32'd0);
        check("t1_mem0", 32'(mem_model[0]), 32'h1234);
        check("t1_mem1", 32'(mem_model[1]), 32'hABCD);
        check("t1_we_count", 32'(we_count), 32'd2);
        // Further input after done is ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("t1_ignore_ready", 32'(in_ready), 32'd0);
        check("t1_ignore_we", 32'(we_count), 32'd2);
        check("t1_hold_done", 32'(done), 32'd1);
        in_valid = 1'b0;

        // Test 2: bad checksum
        do_reset();
        stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_all(1'b0);
        check("t2_error", 32'(error), 32'd1);
        check("t2_done", 32'(done), 32'd0);
        check("t2_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t2_we_count", 32'(we_count), 32'd2);
        check("t2_mem1", 32'(mem_model[1]), 32'hABCD);
        repeat (3) @(negedge clk);
        check("t2_error_sticky", 32'(error), 32'd1);

        // Test 3: gapped valid
        do_reset();
        stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_all(1'b1);
        check("t3_mem0", 32'(mem_model[0]), 32'h1234);
        check("t3_mem1", 32'(mem_model[1]), 32'hABCD);
        check("t3_we_count", 32'(we_count), 32'd2);
        check("t3_done", 32'(done), 32'd1);

        // Test 4: empty image
        do_reset();
        stim = '{8'h00, 8'h00};
        send_all(1'b0);
        check("t4a_we_count", 32'(we_count), 32'd0);
        check("t4a_done", 32'(done), 32'd1);
        check("t4a_cpu_rst", 32'(cpu_rst), 32'd1);
        do_reset();
        stim = '{8'h00, 8'h05};
        send_all(1'b0);
        check("t4b_error", 32'(error), 32'd1);
        check("t4b_done", 32'(done), 32'd0);

        // Test 5: address wrap with 4-entry RAM; CSUM = 01^02^03^04^05 = 01
        do_reset();
        stim = '{8'h05, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03,
                 8'h00, 8'h04, 8'h00, 8'h05, 8'h01};
        send_all(1'b0);
        check("t5_we_count", 32'(we_count), 32'd5);
        check("t5_log_size", 32'(addr_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < addr_log.size(); i++)
            check($sformatf("t5_addr%0d", i), 32'(addr_log[i]), 32'(i % 4));
        check("t5_mem0", 32'(mem_model[0]), 32'h0005);
        check("t5_mem3", 32'(mem_model[3]), 32'h0004);
        check("t5_done", 32'(done), 32'd1);
        check("t5_error", 32'(error), 32'd0);

        // Test 6: async reset mid-load, then a clean reload
        do_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check("t6_mem_we", 32'(mem_we), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_mem_wdata", 32'(mem_wdata), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_cpu_rst", 32'(cpu_rst), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        clear_board();
        rst = 1'b1;
        stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_all(1'b0);
        check("t6_mem0", 32'(mem_model[0]), 32'h1234);
        check("t6_mem1", 32'(mem_model[1]), 32'hABCD);
        check("t6_we_count", 32'(we_count), 32'd2);
        check("t6_done_after", 32'(done), 32'd1);
        check("t6_cpu_rst_after", 32'(cpu_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
